// File: rtl/mips_wb_pkg.sv
// Shared types and constants for the dual-lane register-file writeback path.
// Sized for the 32-entry MIPS32 register file.
package mips_wb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 32;

    typedef struct packed {
        logic                 we;
        logic [REG_IDX_W-1:0] idx;
        logic [DATA_W-1:0]    data;
    } wb_req_t;

    // One-hot register mask; r0 is hard-wired to zero and never tracked.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (idx != '0) m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_aes_fifo.sv
// Small synchronous FIFO for AES writeback results. No bypass: a pushed entry
// is visible at dout from the cycle after the push.
module wb_aes_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          push_ok;
    logic          pop_ok;

    // full is a flop, so a pop in a full cycle cannot make room for a push in that same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: lanes own their ports, queued AES results
// fill idle ports, plus the pending-write scoreboard and starvation bubble request.
module wb_port_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int DATA_W       = mips_wb_pkg::DATA_W
) (
    input  logic                              in_clk,
    input  logic                              in_rst_n,
    input  logic                              in_wb0_RegWr,
    input  logic [mips_wb_pkg::REG_IDX_W-1:0] in_wb0_rd_idx,
    input  logic [DATA_W-1:0]                 in_wb0_data,
    input  logic                              in_wb1_RegWr,
    input  logic [mips_wb_pkg::REG_IDX_W-1:0] in_wb1_rd_idx,
    input  logic [DATA_W-1:0]                 in_wb1_data,
    input  logic                              in_aes_issue_valid,
    input  logic [mips_wb_pkg::REG_IDX_W-1:0] in_aes_issue_rd_idx,
    input  logic                              in_aes_valid,
    input  logic [mips_wb_pkg::REG_IDX_W-1:0] in_aes_rd_idx,
    input  logic [DATA_W-1:0]                 in_aes_data,
    output logic                              out_aes_ready,
    output logic                              out_port0_we,
    output logic [mips_wb_pkg::REG_IDX_W-1:0] out_port0_idx,
    output logic [DATA_W-1:0]                 out_port0_data,
    output logic                              out_port1_we,
    output logic [mips_wb_pkg::REG_IDX_W-1:0] out_port1_idx,
    output logic [DATA_W-1:0]                 out_port1_data,
    output logic [31:0]                       out_pend_mask,
    output logic                              out_stall_lane1,
    output logic [$clog2(FIFO_DEPTH):0]       out_fifo_cnt
);

    import mips_wb_pkg::*;

    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int ENTRY_W  = REG_IDX_W + DATA_W;

    logic                 lane0_we;
    logic                 lane1_we;
    logic [ENTRY_W-1:0]   head;
    logic [REG_IDX_W-1:0] head_idx;
    logic [DATA_W-1:0]    head_data;
    logic                 head_we;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_cnt;
    logic                 push;
    logic                 drain_p0;
    logic                 drain_p1;
    logic                 drain;
    logic [NUM_REGS-1:0]  pend_q;
    logic [NUM_REGS-1:0]  pend_next;
    logic [STARVE_W-1:0]  starve_q;
    logic [STARVE_W-1:0]  starve_next;
    logic                 stall_q;
    logic                 stall_next;

    // A lane write to r0 is architecturally a no-op, so it leaves the port free.
    assign lane0_we = in_wb0_RegWr && (in_wb0_rd_idx != '0);
    assign lane1_we = in_wb1_RegWr && (in_wb1_rd_idx != '0);

    assign push = in_aes_valid && !fifo_full;

    wb_aes_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (in_clk),
        .rst_n (in_rst_n),
        .push  (push),
        .pop   (drain),
        .din   ({in_aes_rd_idx, in_aes_data}),
        .dout  (head),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_idx  = head[ENTRY_W-1:DATA_W];
    assign head_data = head[DATA_W-1:0];
    assign head_we   = (head_idx != '0);

    // Port 0 is preferred for the head; port 1 only when lane 0 holds port 0.
    assign drain_p0 = !fifo_empty && !lane0_we;
    assign drain_p1 = !fifo_empty && lane0_we && !lane1_we;
    assign drain    = drain_p0 || drain_p1;

    always_comb begin
        out_port0_we   = 1'b0;
        out_port0_idx  = '0;
        out_port0_data = '0;
        out_port1_we   = 1'b0;
        out_port1_idx  = '0;
        out_port1_data = '0;
        if (lane0_we) begin
            out_port0_we   = 1'b1;
            out_port0_idx  = in_wb0_rd_idx;
            out_port0_data = in_wb0_data;
        end else if (drain_p0 && head_we) begin
            out_port0_we   = 1'b1;
            out_port0_idx  = head_idx;
            out_port0_data = head_data;
        end
        if (lane1_we) begin
            out_port1_we   = 1'b1;
            out_port1_idx  = in_wb1_rd_idx;
            out_port1_data = in_wb1_data;
        end else if (drain_p1 && head_we) begin
            out_port1_we   = 1'b1;
            out_port1_idx  = head_idx;
            out_port1_data = head_data;
        end
    end

    // A new issue to a register that is committing this cycle keeps the bit set.
    always_comb begin
        pend_next = pend_q & ~(drain ? reg_onehot(head_idx) : '0);
        if (in_aes_issue_valid) pend_next = pend_next | reg_onehot(in_aes_issue_rd_idx);
    end

    // Stall rises on the edge that completes STARVE_LIMIT waiting cycles and is
    // held until the head finally drains.
    always_comb begin
        starve_next = starve_q;
        stall_next  = stall_q;
        if (fifo_empty || drain) begin
            starve_next = '0;
        end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_next = starve_q + STARVE_W'(1);
        end
        if (fifo_empty || drain) begin
            stall_next = 1'b0;
        end else if (starve_next == STARVE_W'(STARVE_LIMIT)) begin
            stall_next = 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            pend_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            pend_q   <= pend_next;
            starve_q <= starve_next;
            stall_q  <= stall_next;
        end
    end

    assign out_aes_ready   = !fifo_full;
    assign out_pend_mask   = pend_q;
    assign out_stall_lane1 = stall_q;
    assign out_fifo_cnt    = fifo_cnt;

endmodule
